// File: rtl/mips_pkg.sv
// Purpose: shared MIPS pipeline constants and the mult/div sequencing state enum.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // Mult/div sequencing state, exported so trace monitors can decode it.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Purpose: bundles the ID/EX hazard inputs and the pipeline-control outputs of hazard_ctrl.
// Latency: n/a (wiring only).
// Backpressure: n/a; pc_en/ifid_en are the stall controls carried on this bundle.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import mips_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_md;
    logic             id_reads_hilo;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             stall_cnt_clr;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             md_start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: presents instruction info, consumes the enables.
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo,
        output ex_rd, ex_mem_read, ex_branch_taken, stall_cnt_clr,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_busy, stall_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo,
        input  ex_rd, ex_mem_read, ex_branch_taken, stall_cnt_clr,
        output pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_busy, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Purpose: tracks the in-flight mult/div op; busy for MD_LATENCY cycles after start.
// Latency: busy rises the cycle after start and stays high exactly MD_LATENCY cycles.
// Backpressure: none; start must not arrive while busy (ID stalls md ops then).
module md_busy_timer
    import mips_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam int CW = $clog2(MD_LATENCY + 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    // State, down-counter and busy flag; reset aborts any in-flight count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == MD_WAIT);
        end
    end

    // Next state: load on start, count down, leave MD_WAIT after the count hits 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (start) begin
                    state_d = MD_WAIT;
                    cnt_d   = CW'(MD_LATENCY);
                end
            end
            MD_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: load-use / mult-div hazard detection, branch flush and stall-cycle counter.
// Latency: control outputs are combinational same-cycle; md_busy and stall_cnt are registered.
// Backpressure: stalls the front end by dropping pc_en/ifid_en and bubbling ID/EX.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_ctrl_if.slave   hz
);

    logic             load_use;
    logic             md_hazard;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt_q;

    md_busy_timer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (hz.md_start),
        .busy  (md_busy)
    );

    assign load_use = hz.ex_mem_read && (hz.ex_rd != ZERO_REG) &&
                      ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

    assign md_hazard = md_busy && (hz.id_is_md || hz.id_reads_hilo);

    // Pipeline control: a taken branch wins (ID is wrong-path), then stalls, then issue.
    always_comb begin
        hz.pc_en       = 1'b1;
        hz.ifid_en     = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.md_start    = 1'b0;
        if (hz.ex_branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (load_use || md_hazard) begin
            hz.pc_en       = 1'b0;
            hz.ifid_en     = 1'b0;
            hz.idex_bubble = 1'b1;
        end else begin
            hz.md_start = hz.id_is_md;
        end
    end

    // Saturating count of stalled (pc_en low) cycles; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (hz.stall_cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (!hz.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign hz.md_busy   = md_busy;
    assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: scoreboard bench for hazard_ctrl with a cycle-arithmetic reference model.
// Latency: expected values are queued per cycle and checked mid-cycle by a monitor.
// Backpressure: n/a.
module tb_hazard_ctrl;

    localparam int L      = 4;
    localparam int CW     = 16;
    localparam int CNTMAX = (1 << CW) - 1;

    typedef struct {
        bit       rst_n;
        bit [4:0] rs, rt, ex_rd;
        bit       uses_rs, uses_rt, is_md, hilo, mem_read, br, clr;
    } stim_t;

    typedef struct {
        int cyc;
        bit pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_busy;
        int stall_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();

    hazard_ctrl #(.MD_LATENCY(L), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    // Reference model state: when the last mult/div issued, and stalls seen.
    bit have_issue = 0;
    int issue_cyc = 0;
    int stall_m = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1'b1, rs: 5'd0, rt: 5'd0, ex_rd: 5'd0, uses_rs: 1'b0,
              uses_rt: 1'b0, is_md: 1'b0, hilo: 1'b0, mem_read: 1'b0, br: 1'b0, clr: 1'b0};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst_n              = s.rst_n;
        hz.id_rs           = s.rs;
        hz.id_rt           = s.rt;
        hz.id_uses_rs      = s.uses_rs;
        hz.id_uses_rt      = s.uses_rt;
        hz.id_is_md        = s.is_md;
        hz.id_reads_hilo   = s.hilo;
        hz.ex_rd           = s.ex_rd;
        hz.ex_mem_read     = s.mem_read;
        hz.ex_branch_taken = s.br;
        hz.stall_cnt_clr   = s.clr;
    endtask

    // One cycle: drive just after the edge, queue the model's expectation, advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        bit   busy, lu, mdh;
        @(posedge clk);
        #1;
        cyc++;
        drive(s);
        busy = s.rst_n && have_issue && (cyc > issue_cyc) && (cyc <= issue_cyc + L);
        lu   = s.mem_read && (s.ex_rd != 0) &&
               ((s.uses_rs && s.rs == s.ex_rd) || (s.uses_rt && s.rt == s.ex_rd));
        mdh  = busy && (s.is_md || s.hilo);
        e.cyc = cyc;
        e.md_busy = busy;
        e.stall_cnt = s.rst_n ? stall_m : 0;
        e.ifid_flush = 0; e.idex_bubble = 0; e.md_start = 0;
        e.pc_en = 1; e.ifid_en = 1;
        if (s.br) begin
            e.ifid_flush = 1; e.idex_bubble = 1;
        end else if (lu || mdh) begin
            e.pc_en = 0; e.ifid_en = 0; e.idex_bubble = 1;
        end else begin
            e.md_start = s.is_md;
        end
        sb.push_back(e);
        if (!s.rst_n) begin
            have_issue = 0;
            stall_m = 0;
            #1;
            checks++;
            if (hz.md_busy !== 1'b0) begin
                failures++;
                $display("FAIL async_reset_busy cyc%0d got=%b want=0", cyc, hz.md_busy);
            end
        end else begin
            if (e.md_start) begin
                have_issue = 1;
                issue_cyc = cyc;
            end
            if (s.clr) stall_m = 0;
            else if (!e.pc_en && stall_m < CNTMAX) stall_m++;
        end
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs; compare against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (hz.pc_en !== e.pc_en || hz.ifid_en !== e.ifid_en ||
                hz.ifid_flush !== e.ifid_flush || hz.idex_bubble !== e.idex_bubble ||
                hz.md_start !== e.md_start || hz.md_busy !== e.md_busy ||
                hz.stall_cnt !== CW'(e.stall_cnt)) begin
                failures++;
                $display("FAIL outputs cyc%0d got pc=%b ifid=%b fl=%b bub=%b st=%b busy=%b cnt=%0d want pc=%b ifid=%b fl=%b bub=%b st=%b busy=%b cnt=%0d",
                         e.cyc, hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_bubble,
                         hz.md_start, hz.md_busy, hz.stall_cnt, e.pc_en, e.ifid_en,
                         e.ifid_flush, e.idex_bubble, e.md_start, e.md_busy, e.stall_cnt);
            end
        end
    end

    initial begin
        stim_t s;
        stim_t lu8;
        int    wait_cnt;

        drive(idle());
        rst_n = 1'b0;

        // Reset state with idle inputs.
        s = idle(); s.rst_n = 1'b0;
        repeat (2) step(s);
        step(idle());

        // Load-use on r8, then the same with r0 as destination.
        lu8 = idle(); lu8.mem_read = 1; lu8.ex_rd = 5'd8; lu8.rs = 5'd8; lu8.uses_rs = 1;
        step(lu8);
        step(idle());
        s = lu8; s.ex_rd = 5'd0; s.rs = 5'd0;
        step(s);
        s = lu8; s.uses_rs = 0; s.rt = 5'd8; s.uses_rt = 1;
        step(s);

        // Branch taken overrides a load-use stall.
        s = lu8; s.br = 1;
        step(s);
        step(idle());

        // mult then dependent mfhi held in ID until it issues.
        s = idle(); s.is_md = 1; step(s);
        s = idle(); s.hilo = 1; repeat (5) step(s);
        step(idle());

        // Back-to-back mult, then an unrelated add during busy, then a branch while busy.
        s = idle(); s.is_md = 1; repeat (6) step(s);
        s = idle(); s.uses_rs = 1; s.rs = 5'd3; step(s);
        s = idle(); s.br = 1; step(s);
        repeat (3) step(idle());

        // Reset two cycles into MD_WAIT, then mfhi after release issues immediately.
        s = idle(); s.is_md = 1; step(s);
        repeat (2) step(idle());
        s = idle(); s.rst_n = 1'b0; step(s);
        s = idle(); s.hilo = 1; repeat (2) step(s);

        // Randomized mix with a narrow register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.ex_rd    = 5'($urandom_range(0, 3));
            s.uses_rs  = 1'($urandom_range(0, 1));
            s.uses_rt  = 1'($urandom_range(0, 1));
            s.mem_read = ($urandom_range(0, 99) < 35);
            s.br       = ($urandom_range(0, 99) < 12);
            s.is_md    = ($urandom_range(0, 99) < 20);
            s.hilo     = ($urandom_range(0, 99) < 20);
            s.clr      = ($urandom_range(0, 99) < 3);
            step(s);
        end

        // Saturation: hold load-use long enough to pin the counter at all-ones, then clear.
        s = idle(); s.clr = 1; step(s);
        repeat (CNTMAX + 3) step(lu8);
        s = lu8; s.clr = 1; step(s);
        repeat (2) step(idle());

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
